// File: rtl/pipe_stage_skid_reg.sv
// Inter-stage pipeline register with a valid/ready handshake and an optional skid entry.
// With SKID=1 the upstream ready comes from registers only, so a downstream stall does not
// ripple combinationally into the previous stage. Flush empties the stage and presents NOP
// while keeping the last PC. Saturating stall/flush counters feed performance monitoring.
module pipe_stage_skid_reg #(
  parameter int                  INSTR_W   = 32,
  parameter int                  PC_W      = 32,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = {INSTR_W{1'b0}},
  parameter int                  SKID      = 1,
  parameter int                  CNT_W     = 16
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               in_ready,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  input  logic               out_ready,
  input  logic               flush,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t               state_q;
  logic [INSTR_W-1:0]   main_instr_q;
  logic [PC_W-1:0]      main_pc_q;
  logic [INSTR_W-1:0]   skid_instr_q;
  logic [PC_W-1:0]      skid_pc_q;
  logic [CNT_W-1:0]     stall_cnt_q;
  logic [CNT_W-1:0]     flush_cnt_q;
  logic [CNT_W-1:0]     stall_cnt_d;
  logic [CNT_W-1:0]     flush_cnt_d;
  logic                 acc;
  logic                 take;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_instr = main_instr_q;
  assign out_pc    = main_pc_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  assign acc  = in_valid & in_ready;
  assign take = out_valid & out_ready;

  // Upstream ready: register-only with a skid entry, pass-through of downstream ready without.
  generate
    if (SKID != 0) begin : g_skid_ready
      assign in_ready = n_reset & (state_q != ST_FULL);
    end else begin : g_flow_ready
      assign in_ready = n_reset & (~out_valid | out_ready);
    end
  endgenerate

  // Saturating next values for the perf counters; a flush only counts if it kills something.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush && (state_q != ST_EMPTY) && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Stage FSM and entry storage; flush beats every transfer, reset beats flush.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q      <= ST_EMPTY;
      main_instr_q <= NOP_INSTR;
      main_pc_q    <= {PC_W{1'b0}};
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= {PC_W{1'b0}};
      stall_cnt_q  <= {CNT_W{1'b0}};
      flush_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      if (flush) begin
        // Any same-cycle accept is dropped; PC is kept for debug visibility.
        state_q      <= ST_EMPTY;
        main_instr_q <= NOP_INSTR;
      end else begin
        case (state_q)
          ST_EMPTY: begin
            if (acc) begin
              state_q      <= ST_ONE;
              main_instr_q <= in_instr;
              main_pc_q    <= in_pc;
            end
          end
          ST_ONE: begin
            if (acc && take) begin
              main_instr_q <= in_instr;
              main_pc_q    <= in_pc;
            end else if (acc) begin
              // Downstream stalled: park the new entry behind the main one.
              state_q      <= ST_FULL;
              skid_instr_q <= in_instr;
              skid_pc_q    <= in_pc;
            end else if (take) begin
              state_q      <= ST_EMPTY;
              main_instr_q <= NOP_INSTR;
            end
          end
          ST_FULL: begin
            // in_ready is low here, so the skid entry is always the next to move up.
            if (take) begin
              state_q      <= ST_ONE;
              main_instr_q <= skid_instr_q;
              main_pc_q    <= skid_pc_q;
            end
          end
          default: begin
            state_q      <= ST_EMPTY;
            main_instr_q <= NOP_INSTR;
          end
        endcase
      end
    end
  end

endmodule
